hwpe_stream_tcdm_load_arbiter_sidech: RTL and testbench

Shares one sidechannel-capable TCDM load FIFO (32-bit address out, 32-bit data back, in-order) between NB_IN load requesters. Requests are picked round-robin. Each accepted request is tagged with the requester index on the FIFO sidechannel. The returned tag steers each response back to its owner. Per-requester credit counters cap outstanding loads. The block sits between HWPE source streamers and the load FIFO instance.

---
 rtl/hwpe_stream_package.sv | 11 +
 rtl/hwpe_stream_rr_select.sv | 32 +++
 rtl/hwpe_stream_tcdm_load_arbiter_sidech.sv | 111 +++++++++++
 tb/tb_hwpe_stream_tcdm_load_arbiter_sidech.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared types and defaults for hwpe stream blocks
package hwpe_stream_package;

  localparam int TCDM_ARB_MAX_OUTSTANDING = 8;

  typedef struct packed {
    logic idle;
    logic err;
  } flags_tcdm_arb_t;

endpackage

// File: rtl/hwpe_stream_rr_select.sv
// rtl/hwpe_stream_rr_select.sv - combinational round-robin pick of the first eligible index at or after ptr
module hwpe_stream_rr_select
  import hwpe_stream_package::*;
#(
  parameter int NB_IN    = 4,
  parameter int ID_WIDTH = (NB_IN > 1) ? $clog2(NB_IN) : 1
) (
  input  logic [NB_IN-1:0]    eligible,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NB_IN-1:0]    grant,
  output logic [ID_WIDTH-1:0] sel,
  output logic                any
);

  logic [NB_IN-1:0]  rot;
  logic [ID_WIDTH:0] sum;

  // Rotate so bit 0 is the pointer position; lowest set bit then wins.
  always_comb begin
    rot = NB_IN'({eligible, eligible} >> ptr);
    sum = {1'b0, ptr};
    for (int k = NB_IN - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
    end
    if (sum >= (ID_WIDTH+1)'(NB_IN)) sum = sum - (ID_WIDTH+1)'(NB_IN);
  end

  assign sel   = sum[ID_WIDTH-1:0];
  assign any   = |rot;
  assign grant = any ? (NB_IN'(1) << sel) : '0;

endmodule

// File: rtl/hwpe_stream_tcdm_load_arbiter_sidech.sv
// rtl/hwpe_stream_tcdm_load_arbiter_sidech.sv - round-robin sharing of a tagged in-order TCDM load FIFO
module hwpe_stream_tcdm_load_arbiter_sidech
  import hwpe_stream_package::*;
#(
  parameter int NB_IN           = 4,
  parameter int ID_WIDTH        = (NB_IN > 1) ? $clog2(NB_IN) : 1,
  parameter int MAX_OUTSTANDING = TCDM_ARB_MAX_OUTSTANDING,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [NB_IN-1:0]           enable_i,
  input  logic [NB_IN-1:0]           in_req_i,
  input  logic [NB_IN*32-1:0]        in_add_i,
  output logic [NB_IN-1:0]           in_gnt_o,
  output logic [NB_IN*32-1:0]        in_r_data_o,
  output logic [NB_IN-1:0]           in_r_valid_o,
  input  logic [NB_IN-1:0]           in_r_ready_i,
  output logic                       fifo_req_o,
  output logic [31:0]                fifo_add_o,
  input  logic                       fifo_gnt_i,
  output logic [ID_WIDTH-1:0]        fifo_sidech_o,
  input  logic [31:0]                fifo_r_data_i,
  input  logic                       fifo_r_valid_i,
  output logic                       fifo_ready_o,
  input  logic [ID_WIDTH-1:0]        fifo_sidech_i,
  input  logic                       fifo_empty_i,
  output logic                       idle_o,
  output logic                       err_o,
  output logic [NB_IN*CNT_WIDTH-1:0] outstanding_o
);

  logic [ID_WIDTH-1:0]  ptr_q;
  logic [ID_WIDTH-1:0]  sel;
  logic [CNT_WIDTH-1:0] cnt_q [NB_IN];
  logic [NB_IN-1:0]     eligible, sel_oh, inc, dec;
  logic                 any, gnt_hs, rsp_hs, id_ok, err_q;
  flags_tcdm_arb_t      flags;

  always_comb begin
    for (int i = 0; i < NB_IN; i++) begin
      eligible[i] = in_req_i[i] & enable_i[i] & (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
    end
  end

  hwpe_stream_rr_select #(
    .NB_IN    (NB_IN),
    .ID_WIDTH (ID_WIDTH)
  ) i_rr_select (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (sel_oh),
    .sel      (sel),
    .any      (any)
  );

  assign fifo_req_o    = any;
  assign fifo_add_o    = in_add_i[32*int'(sel) +: 32];
  assign fifo_sidech_o = sel;
  assign in_gnt_o      = fifo_gnt_i ? sel_oh : '0;

  // Tags beyond NB_IN have no owner: drain them so the FIFO cannot lock up.
  assign id_ok        = {1'b0, fifo_sidech_i} < (ID_WIDTH+1)'(NB_IN);
  assign in_r_data_o  = {NB_IN{fifo_r_data_i}};
  assign in_r_valid_o = (id_ok && fifo_r_valid_i) ? (NB_IN'(1) << fifo_sidech_i) : '0;
  assign fifo_ready_o = id_ok ? in_r_ready_i[fifo_sidech_i] : 1'b1;

  assign gnt_hs = any & fifo_gnt_i;
  assign rsp_hs = fifo_r_valid_i & fifo_ready_o & id_ok;
  assign inc    = gnt_hs ? sel_oh : '0;
  assign dec    = rsp_hs ? (NB_IN'(1) << fifo_sidech_i) : '0;

  always_comb begin
    flags.idle = fifo_empty_i;
    for (int i = 0; i < NB_IN; i++) begin
      if (cnt_q[i] != '0) flags.idle = 1'b0;
    end
    flags.err = err_q;
  end

  assign idle_o = flags.idle;
  assign err_o  = flags.err;

  for (genvar g = 0; g < NB_IN; g++) begin : g_cnt_out
    assign outstanding_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NB_IN; i++) cnt_q[i] <= '0;
    end else begin
      if (gnt_hs) begin
        ptr_q <= ({1'b0, sel} == (ID_WIDTH+1)'(NB_IN - 1)) ? '0 : sel + 1'b1;
      end
      if (fifo_r_valid_i && !id_ok) err_q <= 1'b1;
      for (int i = 0; i < NB_IN; i++) begin
        if (inc[i] && !dec[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NB_IN; g++) begin : g_underflow
    assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
                     !(dec[g] && !inc[g] && cnt_q[g] == '0));
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_arbiter_sidech.sv
// tb/tb_hwpe_stream_tcdm_load_arbiter_sidech.sv - self-checking bench with a queue-based load FIFO model
module tb_hwpe_stream_tcdm_load_arbiter_sidech;

  localparam int NB = 4, MAXO = 2, IDW = 2, CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clr, f_gnt, f_rvalid, f_empty, f_req, f_ready, idle, err;
  logic [NB-1:0]     en, req, rready, in_gnt, rvalid_o;
  logic [31:0]       addr_a [NB];
  logic [NB*32-1:0]  add, rdata_o;
  logic [31:0]       f_add, f_rdata;
  logic [IDW-1:0]    f_side, f_side_o;
  logic [NB*CW-1:0]  outst;

  always_comb begin
    add = '0;
    for (int i = 0; i < NB; i++) add[i*32 +: 32] = addr_a[i];
  end

  hwpe_stream_tcdm_load_arbiter_sidech #(
    .NB_IN(NB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .enable_i(en),
    .in_req_i(req), .in_add_i(add), .in_gnt_o(in_gnt),
    .in_r_data_o(rdata_o), .in_r_valid_o(rvalid_o), .in_r_ready_i(rready),
    .fifo_req_o(f_req), .fifo_add_o(f_add), .fifo_gnt_i(f_gnt), .fifo_sidech_o(f_side_o),
    .fifo_r_data_i(f_rdata), .fifo_r_valid_i(f_rvalid), .fifo_ready_o(f_ready),
    .fifo_sidech_i(f_side), .fifo_empty_i(f_empty),
    .idle_o(idle), .err_o(err), .outstanding_o(outst)
  );

  // Second instance with NB_IN=3 so an out-of-range tag can be returned.
  logic           rst3_n, clr3, f_rvalid3, f_req3, f_ready3, idle3, err3;
  logic [2:0]     rvalid3, gnt3, rready3;
  logic [95:0]    rdata3;
  logic [31:0]    f_add3;
  logic [1:0]     f_side3, f_side_o3;
  logic [5:0]     outst3;

  hwpe_stream_tcdm_load_arbiter_sidech #(
    .NB_IN(3), .MAX_OUTSTANDING(2)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .clear_i(clr3), .enable_i(3'b111),
    .in_req_i(3'b000), .in_add_i(96'h0), .in_gnt_o(gnt3),
    .in_r_data_o(rdata3), .in_r_valid_o(rvalid3), .in_r_ready_i(rready3),
    .fifo_req_o(f_req3), .fifo_add_o(f_add3), .fifo_gnt_i(1'b0), .fifo_sidech_o(f_side_o3),
    .fifo_r_data_i(32'h1234_5678), .fifo_r_valid_i(f_rvalid3), .fifo_ready_o(f_ready3),
    .fifo_sidech_i(f_side3), .fifo_empty_i(1'b1),
    .idle_o(idle3), .err_o(err3), .outstanding_o(outst3)
  );

  typedef struct { int tag; logic [31:0] data; } ent_t;

  int   n_chk = 0, n_fail = 0;
  int   m_ptr;
  int   m_cnt [NB];
  ent_t q [$];
  int   glog [$];
  bit   cont_mode, rsp_en;

  // One clock cycle: present FIFO response, check outputs mid-cycle, advance model.
  task automatic tick();
    logic [NB-1:0] elig, e_gnt, e_rv;
    int sel, id;
    bit any, e_ready, e_idle, ghs, rhs, rst_now;
    ent_t e;
    f_empty = (q.size() == 0);
    if (rsp_en && q.size() > 0) begin
      f_rvalid = 1'b1; f_side = IDW'(q[0].tag); f_rdata = q[0].data;
    end else begin
      f_rvalid = 1'b0; f_side = IDW'($urandom); f_rdata = $urandom;
    end
    #4;
    for (int i = 0; i < NB; i++) elig[i] = req[i] & en[i] & (m_cnt[i] < MAXO);
    any = 0; sel = 0;
    for (int k = 0; k < NB; k++) begin
      if (!any && elig[(m_ptr + k) % NB]) begin any = 1; sel = (m_ptr + k) % NB; end
    end
    e_gnt   = (any && f_gnt) ? (NB'(1) << sel) : '0;
    id      = int'(f_side);
    e_rv    = f_rvalid ? (NB'(1) << id) : '0;
    e_ready = rready[id];
    e_idle  = f_empty;
    for (int i = 0; i < NB; i++) if (m_cnt[i] != 0) e_idle = 0;

    n_chk++; if (f_req !== any) begin n_fail++; $display("FAIL fifo_req got %b exp %b", f_req, any); end
    if (any) begin
      n_chk++; if (f_add !== addr_a[sel]) begin n_fail++; $display("FAIL fifo_add got %h exp %h", f_add, addr_a[sel]); end
      n_chk++; if (f_side_o !== IDW'(sel)) begin n_fail++; $display("FAIL fifo_sidech got %0d exp %0d", f_side_o, sel); end
    end
    n_chk++; if (in_gnt !== e_gnt) begin n_fail++; $display("FAIL in_gnt got %b exp %b", in_gnt, e_gnt); end
    n_chk++; if (rvalid_o !== e_rv) begin n_fail++; $display("FAIL in_r_valid got %b exp %b", rvalid_o, e_rv); end
    n_chk++; if (f_ready !== e_ready) begin n_fail++; $display("FAIL fifo_ready got %b exp %b", f_ready, e_ready); end
    n_chk++; if (idle !== e_idle) begin n_fail++; $display("FAIL idle got %b exp %b", idle, e_idle); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err got %b exp 0", err); end
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (outst[i*CW +: CW] !== CW'(m_cnt[i])) begin
        n_fail++; $display("FAIL outstanding[%0d] got %0d exp %0d", i, outst[i*CW +: CW], m_cnt[i]);
      end
    end
    if (f_rvalid) begin
      n_chk++; if (rdata_o !== {NB{f_rdata}}) begin n_fail++; $display("FAIL r_data got %h exp %h", rdata_o, {NB{f_rdata}}); end
    end

    rst_now = !rst_n || clr;
    ghs = any && f_gnt;
    rhs = f_rvalid && rready[id];
    if (rst_now) begin
      m_ptr = 0;
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
      q.delete();
    end else begin
      if (rhs) begin m_cnt[id]--; void'(q.pop_front()); end
      if (ghs) begin
        m_cnt[sel]++; m_ptr = (sel + 1) % NB;
        e.tag = sel; e.data = {8'(sel), 24'($urandom)};
        q.push_back(e); glog.push_back(sel);
      end
    end
    @(posedge clk); #1;
    if (ghs && !rst_now) begin
      if (!cont_mode) req[sel] = 1'b0;
      addr_a[sel] = $urandom;
    end
  endtask

  task automatic drain();
    req = '0; cont_mode = 0; rsp_en = 1; rready = '1; en = '1; f_gnt = 1;
    for (int c = 0; c < 40 && q.size() > 0; c++) tick();
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL drain_timeout left %0d exp 0", q.size()); end
    tick();
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL idle_after_drain got %b exp 1", idle); end
  endtask

  task automatic test_reset();
    rst_n = 0; en = '1; req = '0;
    @(posedge clk); #1;
    m_ptr = 0; for (int i = 0; i < NB; i++) m_cnt[i] = 0; q.delete();
    n_chk++; if (in_gnt !== '0) begin n_fail++; $display("FAIL rst_gnt got %b exp 0", in_gnt); end
    n_chk++; if (f_req !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_req got %b exp 0", f_req); end
    n_chk++; if (rvalid_o !== '0) begin n_fail++; $display("FAIL rst_r_valid got %b exp 0", rvalid_o); end
    n_chk++; if (outst !== '0) begin n_fail++; $display("FAIL rst_outstanding got %h exp 0", outst); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b exp 1", idle); end
    f_empty = 0; #1;
    n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rst_idle_nonempty got %b exp 0", idle); end
    f_empty = 1; rst_n = 1;
  endtask

  task automatic test_round_robin();
    glog.delete();
    cont_mode = 1; req = '1; en = '1; f_gnt = 1; rready = '1; rsp_en = 1;
    repeat (12) tick();
    n_chk++; if (glog.size() != 12) begin n_fail++; $display("FAIL rr_count got %0d exp 12", glog.size()); end
    foreach (glog[k]) begin
      n_chk++; if (glog[k] != k % NB) begin n_fail++; $display("FAIL rr_order[%0d] got %0d exp %0d", k, glog[k], k % NB); end
    end
    drain();
  endtask

  task automatic test_credit();
    int exp_o [6] = '{2, 3, 0, 2, 3, 0};
    glog.delete();
    cont_mode = 1; req = 4'b0010; f_gnt = 1; rready = 4'b1101; rsp_en = 0;
    repeat (4) tick();
    n_chk++; if (glog.size() != 2 || glog[0] != 1 || glog[1] != 1) begin
      n_fail++; $display("FAIL credit_grants_to_1 got %0d grants exp 2", glog.size());
    end
    n_chk++; if (f_req !== 1'b0) begin n_fail++; $display("FAIL credit_block got %b exp 0", f_req); end
    glog.delete(); req = '1;
    repeat (8) tick();
    n_chk++; if (glog.size() != 6) begin n_fail++; $display("FAIL credit_others_count got %0d exp 6", glog.size()); end
    for (int k = 0; k < 6 && k < glog.size(); k++) begin
      n_chk++; if (glog[k] != exp_o[k]) begin n_fail++; $display("FAIL credit_order[%0d] got %0d exp %0d", k, glog[k], exp_o[k]); end
    end
    n_chk++; if (outst[3:2] !== 2'd2) begin n_fail++; $display("FAIL credit_outstanding1 got %0d exp 2", outst[3:2]); end
    drain();
  endtask

  task automatic test_same_cycle();
    cont_mode = 1; req = 4'b0100; f_gnt = 1; rready = '1; rsp_en = 0;
    tick();
    n_chk++; if (outst[5:4] !== 2'd1) begin n_fail++; $display("FAIL same_first got %0d exp 1", outst[5:4]); end
    rsp_en = 1;
    tick();
    n_chk++; if (outst[5:4] !== 2'd1) begin n_fail++; $display("FAIL same_cycle got %0d exp 1", outst[5:4]); end
    req = '0;
    tick();
    n_chk++; if (outst[5:4] !== 2'd0) begin n_fail++; $display("FAIL same_rsp_only got %0d exp 0", outst[5:4]); end
    drain();
  endtask

  task automatic test_disable();
    cont_mode = 1; req = 4'b0001; f_gnt = 1; rready = '1; rsp_en = 0;
    repeat (3) tick();
    n_chk++; if (outst[1:0] !== 2'd2) begin n_fail++; $display("FAIL dis_inflight got %0d exp 2", outst[1:0]); end
    glog.delete();
    en = 4'b1110; req = 4'b0011; rsp_en = 1;
    repeat (6) tick();
    n_chk++; if (glog.size() == 0) begin n_fail++; $display("FAIL dis_others got 0 grants exp >0"); end
    foreach (glog[k]) begin
      n_chk++; if (glog[k] == 0) begin n_fail++; $display("FAIL dis_grant0 got grant to 0 exp none"); end
    end
    n_chk++; if (outst[1:0] !== 2'd0) begin n_fail++; $display("FAIL dis_drained got %0d exp 0", outst[1:0]); end
    drain();
  endtask

  task automatic test_reset_midburst();
    cont_mode = 1; req = '1; f_gnt = 1; rready = '1; rsp_en = 0;
    repeat (3) tick();
    rst_n = 0;
    tick();
    rst_n = 1; req = '0; f_empty = 1; #1;
    n_chk++; if (outst !== '0) begin n_fail++; $display("FAIL mid_rst_cnt got %h exp 0", outst); end
    n_chk++; if (in_gnt !== '0) begin n_fail++; $display("FAIL mid_rst_gnt got %b exp 0", in_gnt); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_rst_idle got %b exp 1", idle); end
    glog.delete(); req = 4'b1010; cont_mode = 0;
    tick();
    n_chk++; if (glog.size() != 1 || glog[0] != 1) begin n_fail++; $display("FAIL mid_rst_ptr got %0d grants exp first=1", glog.size()); end
    drain();
  endtask

  task automatic test_random();
    cont_mode = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin req[i] = 1'b1; addr_a[i] = $urandom; end
      end
      if ($urandom_range(0, 15) == 0) en = NB'($urandom);
      f_gnt  = ($urandom_range(0, 3) != 0);
      rready = NB'($urandom);
      rsp_en = $urandom_range(0, 1) == 1;
      clr    = ($urandom_range(0, 63) == 0);
      tick();
    end
    clr = 0;
    drain();
  endtask

  task automatic test_err();
    rst3_n = 0; @(posedge clk); #1; rst3_n = 1;
    n_chk++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL err_reset got %b exp 0", err3); end
    f_side3 = 2'd2; f_rvalid3 = 1; rready3 = 3'b000; #1;
    n_chk++; if (f_ready3 !== 1'b0) begin n_fail++; $display("FAIL err_valid_ready got %b exp 0", f_ready3); end
    n_chk++; if (rvalid3 !== 3'b100) begin n_fail++; $display("FAIL err_valid_route got %b exp 100", rvalid3); end
    f_side3 = 2'd3; #1;
    n_chk++; if (f_ready3 !== 1'b1) begin n_fail++; $display("FAIL err_bad_ready got %b exp 1", f_ready3); end
    n_chk++; if (rvalid3 !== 3'b000) begin n_fail++; $display("FAIL err_bad_valid got %b exp 000", rvalid3); end
    @(posedge clk); #1; f_rvalid3 = 0; f_side3 = 2'd0;
    n_chk++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", err3); end
    repeat (2) @(posedge clk); #1;
    n_chk++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err3); end
    n_chk++; if (idle3 !== 1'b1) begin n_fail++; $display("FAIL err_idle got %b exp 1", idle3); end
    clr3 = 1; @(posedge clk); #1; clr3 = 0;
    n_chk++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err3); end
  endtask

  initial begin
    rst_n = 0; clr = 0; en = '0; req = '0; f_gnt = 0; rready = '0;
    f_rvalid = 0; f_rdata = '0; f_side = '0; f_empty = 1;
    for (int i = 0; i < NB; i++) addr_a[i] = 32'h1000 * (i + 1);
    rst3_n = 0; clr3 = 0; f_rvalid3 = 0; f_side3 = '0; rready3 = '0;
    cont_mode = 0; rsp_en = 0;
    test_reset();
    test_round_robin();
    test_credit();
    test_same_cycle();
    test_disable();
    test_reset_midburst();
    test_random();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
